// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, byte-mask helpers.
// ISSUE1/WAIT1 exist only when LSU_MISALIGNED_SPLIT_EN is defined.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0
`ifdef LSU_MISALIGNED_SPLIT_EN
        ,
        ISSUE1,
        WAIT1
`endif
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            default:     size_mask = 4'b1111;
        endcase
    endfunction

    // Unsigned loads have no store counterpart.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the two-word read view down by the byte offset, truncates, extends.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [63:0] rd64,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'(rd64 >> {off, 3'b000});
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit; misaligned H/W accesses split in two when LSU_MISALIGNED_SPLIT_EN is defined.
// Latency: error T+1, store T+2, load T+3; split store T+3, split load T+5 (T = accept edge).
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state;
    logic                  op_we;
    logic [2:0]            op_f3;
    logic [1:0]            op_off;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] a0;
    logic [7:0]            be64;
    logic [DATA_WIDTH-1:0] wd_lo;
    logic                  mis;
    logic                  reject;
    logic [63:0]           rd64;
    logic [DATA_WIDTH-1:0] ld_data;

    assign off       = req_addr[1:0];
    assign a0        = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign be64      = {4'b0000, size_mask(req_funct3)} << off;
    assign mis       = |be64[7:4];
    assign req_ready = (state == IDLE);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [63:0]           wd64;
    logic [ADDR_WIDTH-1:0] op_a1;
    logic [3:0]            op_be_hi;
    logic [DATA_WIDTH-1:0] op_wd_hi;
    logic [DATA_WIDTH-1:0] rd0_q;
    logic                  op_mis;

    assign wd64   = {32'b0, req_wdata} << {off, 3'b000};
    assign wd_lo  = wd64[31:0];
    assign reject = !f3_legal(req_funct3, req_we);
    assign rd64   = (state == WAIT1) ? {mem_rdata, rd0_q} : {32'b0, mem_rdata};
`else
    assign wd_lo  = req_wdata << {off, 3'b000};
    assign reject = !f3_legal(req_funct3, req_we) || mis;
    assign rd64   = {32'b0, mem_rdata};
`endif

    lsu_load_align u_align (
        .funct3 (op_f3),
        .off    (op_off),
        .rd64   (rd64),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_f3      <= '0;
            op_off     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            op_a1      <= '0;
            op_be_hi   <= '0;
            op_wd_hi   <= '0;
            rd0_q      <= '0;
            op_mis     <= 1'b0;
`endif
        end else begin
            // Strobes only live for the single ISSUE cycle that sets them.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we  <= req_we;
                        op_f3  <= req_funct3;
                        op_off <= off;
                        if (reject) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ISSUE0;
                            mem_addr  <= a0;
                            mem_wdata <= wd_lo;
                            mem_we    <= req_we;
                            mem_be    <= be64[3:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                            op_a1    <= a0 + ADDR_WIDTH'(4);
                            op_be_hi <= be64[7:4];
                            op_wd_hi <= wd64[63:32];
                            op_mis   <= mis;
`endif
                        end
                    end
                end
                ISSUE0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (op_mis && op_we) begin
                        state     <= ISSUE1;
                        mem_addr  <= op_a1;
                        mem_wdata <= op_wd_hi;
                        mem_we    <= 1'b1;
                        mem_be    <= op_be_hi;
                    end else
`endif
                    if (op_we) begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT0;
                    end
                end
                WAIT0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (op_mis) begin
                        state     <= ISSUE1;
                        rd0_q     <= mem_rdata;
                        mem_addr  <= op_a1;
                        mem_wdata <= op_wd_hi;
                        mem_be    <= op_be_hi;
                    end else
`endif
                    begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                ISSUE1: begin
                    if (op_we) begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT1;
                    end
                end
                WAIT1: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_data;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-addressed reference memory plus per-cycle expectations.
// Honours LSU_MISALIGNED_SPLIT_EN the same way the design does.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata)
    );

    typedef struct { logic err; logic [31:0] rdata; } resp_t;
    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } acc_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    resp_t       exp_resp [int];
    acc_t        exp_acc [int];
    bit          exp_busy [int];
    acc_t        obs [$];
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] stub [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide data memory stand-in: byte-enabled write, read data one cycle after the address.
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_we) begin
            w = stub.exists(mem_addr[31:2]) ? stub[mem_addr[31:2]] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            stub[mem_addr[31:2]] = w;
        end
        mem_rdata <= stub.exists(mem_addr[31:2]) ? stub[mem_addr[31:2]] : 32'h0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, !exp_busy.exists(cyc)});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp.exists(cyc)});
            if (exp_resp.exists(cyc)) begin
                check("resp_err", {31'b0, resp_err}, {31'b0, exp_resp[cyc].err});
                check("resp_rdata", resp_rdata, exp_resp[cyc].rdata);
                last_err   = resp_err;
                last_rdata = resp_rdata;
                exp_resp.delete(cyc);
            end
            if (exp_acc.exists(cyc)) begin
                check("mem_we", {31'b0, mem_we}, {31'b0, exp_acc[cyc].we});
                check("mem_be", {28'b0, mem_be}, {28'b0, exp_acc[cyc].be});
                check("mem_addr", mem_addr, exp_acc[cyc].addr);
                if (exp_acc[cyc].we) check("mem_wdata", mem_wdata, exp_acc[cyc].wdata);
                obs.push_back('{mem_we, mem_be, mem_addr, mem_wdata});
                exp_acc.delete(cyc);
            end else begin
                check("mem_we_idle", {31'b0, mem_we}, 32'h0);
                check("mem_be_idle", {28'b0, mem_be}, 32'h0);
            end
            exp_busy.delete(cyc);
        end
    end

    // Reference: byte-level memory, sizes and offsets straight from the RV32I rules.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int          n, t, sz, lat, j;
        bit          legal, mis, err;
        logic [31:0] val, d;
        acc_t        a;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'h1);
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we);
        mis   = (int'(addr[1:0]) + sz) > 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
        err = !legal;
`else
        err = !legal || mis;
`endif
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        t = cyc;
        if (err) begin
            exp_resp[t+1] = '{1'b1, 32'h0};
        end else begin
            lat = we ? (mis ? 3 : 2) : (mis ? 5 : 3);
            for (int k = 0; k < (mis ? 2 : 1); k++) begin
                a.we    = we;
                a.addr  = (addr & ~32'h3) + 32'(4 * k);
                a.be    = 4'b0;
                a.wdata = 32'h0;
                for (int i = 0; i < 4; i++) begin
                    d       = a.addr + 32'(i) - addr;
                    a.be[i] = d < 32'(sz);
                    j       = 4 * k + i - int'(addr[1:0]);
                    if (j >= 0 && j < 4) a.wdata[8*i +: 8] = wd[8*j +: 8];
                end
                exp_acc[t + 1 + k * (we ? 1 : 2)] = a;
            end
            val = 32'h0;
            for (int b = 0; b < sz; b++) val[8*b +: 8] = rbyte(addr + 32'(b));
            if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
            if (we) for (int b = 0; b < sz; b++) ref_mem[addr + 32'(b)] = wd[8*b +: 8];
            exp_resp[t+lat] = '{1'b0, we ? 32'h0 : val};
            for (int k = 1; k < lat; k++) exp_busy[t+k] = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        obs.delete();
        do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF); drain();
        check("sw_be", {28'b0, obs[0].be}, 32'hF);
        check("sw_addr", obs[0].addr, 32'h100);
        do_req(1'b0, 3'b010, 32'h100, 32'h0); drain();
        check("lw_data", last_rdata, 32'hDEAD_BEEF);

        obs.delete();
        do_req(1'b1, 3'b000, 32'h103, 32'h0000_0080); drain();
        check("sb_be", {28'b0, obs[0].be}, 32'h8);
        check("sb_lane3", {24'b0, obs[0].wdata[31:24]}, 32'h80);
        do_req(1'b0, 3'b000, 32'h103, 32'h0); drain();
        check("lb_data", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h103, 32'h0); drain();
        check("lbu_data", last_rdata, 32'h0000_0080);

        do_req(1'b1, 3'b010, 32'h100, 32'h8001_1234);
        do_req(1'b0, 3'b001, 32'h102, 32'h0); drain();
        check("lh_data", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'b101, 32'h102, 32'h0); drain();
        check("lhu_data", last_rdata, 32'h0000_8001);

        obs.delete();
        do_req(1'b0, 3'b010, 32'h101, 32'h0); drain();
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("lw101_err", {31'b0, last_err}, 32'h0);
        check("lw101_data", last_rdata, 32'h0080_0112);
        check("lw101_accesses", obs.size(), 32'd2);

        obs.delete();
        do_req(1'b1, 3'b010, 32'h100, 32'h4433_2211);
        do_req(1'b1, 3'b010, 32'h104, 32'h8877_6655); drain();
        obs.delete();
        do_req(1'b0, 3'b010, 32'h103, 32'h0); drain();
        check("split_n", obs.size(), 32'd2);
        check("split_a0", obs[0].addr, 32'h100);
        check("split_be0", {28'b0, obs[0].be}, 32'h8);
        check("split_a1", obs[1].addr, 32'h104);
        check("split_be1", {28'b0, obs[1].be}, 32'h7);
        check("split_data", last_rdata, 32'h7766_5544);
`else
        check("lw101_err", {31'b0, last_err}, 32'h1);
        check("lw101_accesses", obs.size(), 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFC + $urandom_range(0, 3);
            else ra = 32'h100 + $urandom_range(0, 31);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
        end
        drain();

        // Reset during the write cycle of a store: write must not land, no response.
        chk_en     = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h108;
        req_wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_we_before", {31'b0, mem_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, mem_we}, 32'h0);
        check("rst_mid_be", {28'b0, mem_be}, 32'h0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_ready", {31'b0, req_ready}, 32'h1);
        check("rst_after_valid", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        check("rst_after_valid2", {31'b0, resp_valid}, 32'h0);
        chk_en = 1'b1;
        do_req(1'b0, 3'b010, 32'h108, 32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
